// File: rtl/id_pipe_dec.sv
// Instruction-decode pipeline stage: decodes one instruction per handshake into a
// registered control bundle and stalls on register hazards tracked by a busy scoreboard.
module id_pipe_dec #(
  parameter int IW = 16,
  parameter int RW = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_rd,
  output logic [RW-1:0] out_ra,
  output logic [RW-1:0] out_rb,
  output logic [CW-1:0] out_c,
  output logic [1:0]    out_seltype,
  output logic [1:0]    out_selop,
  output logic          out_selb,
  output logic          out_jsel,
  output logic          out_cbzsel,
  output logic          out_msel,
  output logic          out_memwen,
  output logic          out_rfen,
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_rd,
  input  logic          flush,
  output logic [15:0]   stall_cnt,
  inout  wire           dvdd,
  inout  wire           dgnd
);

  localparam int NREG = 2 ** RW;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and a held bundle stays stable while ready is low.

  logic [3:0]      op;
  logic [RW-1:0]   d_rd, d_ra, d_rb;
  logic [CW-1:0]   d_c;
  logic            d_selb, d_jsel, d_cbzsel, d_msel, d_memwen, d_rfen;
  logic            rd_chk, ra_chk, rb_chk;
  logic [NREG-1:0] busy, busy_next, blocked;
  logic            hazard, accept, issue;
  logic            unused_bits;

  assign unused_bits = ^{dvdd, dgnd, in_instr};

  assign op   = in_instr[IW-1 -: 4];
  assign d_rd = in_instr[IW-5 -: RW];
  assign d_ra = in_instr[IW-5-RW -: RW];
  assign d_rb = in_instr[RW-1:0];
  assign d_c  = in_instr[CW-1:0];

  always_comb begin
    d_selb = 1'b0;
    case (op)
      4'h0, 4'h8, 4'h9, 4'hA, 4'hD, 4'hE, 4'hF: d_selb = 1'b1;
      default: d_selb = 1'b0;
    endcase
  end

  assign d_memwen = (op == 4'h9);
  assign d_rfen   = !(op == 4'h9 || op == 4'hE || op == 4'hF);
  assign d_jsel   = (op == 4'hF);
  assign d_msel   = (op == 4'h8);
  assign d_cbzsel = (op == 4'hE);

  // Which fields of the incoming instruction are sources (or a pending write target).
  assign ra_chk = !(op == 4'hA || op == 4'hF);
  assign rb_chk = !d_selb;
  assign rd_chk = d_memwen | d_rfen;

  // A register is blocked if retired-pending or about to be written by the held bundle.
  assign blocked = busy | ((out_valid && out_rfen)
                   ? ({{(NREG-1){1'b0}}, 1'b1} << out_rd) : '0);

  assign hazard = in_valid & ((ra_chk & blocked[d_ra]) |
                              (rb_chk & blocked[d_rb]) |
                              (rd_chk & blocked[d_rd]));

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign issue    = out_valid && out_ready && out_rfen && !flush;

  // Retire first, then issue, so a same-cycle issue to the retiring register stays busy.
  always_comb begin
    busy_next = busy;
    if (wb_valid) busy_next[wb_rd] = 1'b0;
    if (issue)    busy_next[out_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_rd      <= '0;
      out_ra      <= '0;
      out_rb      <= '0;
      out_c       <= '0;
      out_seltype <= '0;
      out_selop   <= '0;
      out_selb    <= 1'b0;
      out_jsel    <= 1'b0;
      out_cbzsel  <= 1'b0;
      out_msel    <= 1'b0;
      out_memwen  <= 1'b0;
      out_rfen    <= 1'b0;
      busy        <= '0;
      stall_cnt   <= '0;
    end else begin
      if (accept) begin
        out_valid   <= 1'b1;
        out_rd      <= d_rd;
        out_ra      <= d_ra;
        out_rb      <= d_rb;
        out_c       <= d_c;
        out_seltype <= op[3:2];
        out_selop   <= op[1:0];
        out_selb    <= d_selb;
        out_jsel    <= d_jsel;
        out_cbzsel  <= d_cbzsel;
        out_msel    <= d_msel;
        out_memwen  <= d_memwen;
        out_rfen    <= d_rfen;
      end else if (flush || (out_valid && out_ready)) begin
        out_valid <= 1'b0;
      end
      busy <= busy_next;
      if (hazard && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_pipe_dec.sv
// Bench for id_pipe_dec: directed scenarios plus random traffic, all outputs compared
// every cycle against a behavioural model of the decode/scoreboard rules.
module tb_id_pipe_dec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_rd, out_ra, out_rb;
  logic [7:0]  out_c;
  logic [1:0]  out_seltype, out_selop;
  logic        out_selb, out_jsel, out_cbzsel, out_msel, out_memwen, out_rfen;
  logic        wb_valid = 1'b0;
  logic [1:0]  wb_rd = '0;
  logic        flush = 1'b0;
  logic [15:0] stall_cnt;
  wire         dvdd = 1'b1;
  wire         dgnd = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  // model state
  bit         m_valid = 0;
  logic [1:0] m_rd = '0, m_ra = '0, m_rb = '0;
  logic [7:0] m_c = '0;
  logic [3:0] m_op = '0;
  logic [5:0] m_flags = '0;  // {selb, jsel, cbzsel, msel, memwen, rfen}
  bit         m_busy [4] = '{0, 0, 0, 0};
  int         m_stall = 0;

  id_pipe_dec #(.IW(16), .RW(2), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_ra(out_ra), .out_rb(out_rb), .out_c(out_c),
    .out_seltype(out_seltype), .out_selop(out_selop),
    .out_selb(out_selb), .out_jsel(out_jsel), .out_cbzsel(out_cbzsel),
    .out_msel(out_msel), .out_memwen(out_memwen), .out_rfen(out_rfen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall_cnt(stall_cnt), .dvdd(dvdd), .dgnd(dgnd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [5:0] dec_flags(input logic [3:0] op);
    bit selb;
    selb = op inside {4'h0, 4'h8, 4'h9, 4'hA, 4'hD, 4'hE, 4'hF};
    return {selb, op == 4'hF, op == 4'hE, op == 4'h8, op == 4'h9,
            !(op inside {4'h9, 4'hE, 4'hF})};
  endfunction

  function automatic bit m_hazard();
    logic [3:0] op;
    logic [5:0] f;
    int rd, ra, rb;
    bit hit, needed, blk;
    op = in_instr[15:12];
    f  = dec_flags(op);
    rd = in_instr[11:10];
    ra = in_instr[9:8];
    rb = in_instr[1:0];
    hit = 0;
    for (int r = 0; r < 4; r++) begin
      needed = (r == ra && !(op inside {4'hA, 4'hF})) || (r == rb && !f[5]) ||
               (r == rd && (op == 4'h9 || f[0]));
      blk = m_busy[r] || (m_valid && m_flags[0] && m_rd == r);
      if (needed && blk) hit = 1;
    end
    return in_valid && hit;
  endfunction

  function automatic bit m_ready();
    return (!m_valid || out_ready) && !m_hazard() && !flush;
  endfunction

  function automatic logic [3:0] m_busy_vec();
    logic [3:0] v;
    for (int r = 0; r < 4; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // Model: advances on each rising edge from the inputs the bench is driving.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_valid = 0; m_rd = '0; m_ra = '0; m_rb = '0; m_c = '0; m_op = '0;
        m_flags = '0; m_stall = 0;
        for (int r = 0; r < 4; r++) m_busy[r] = 0;
      end else begin
        bit acc, iss, hz;
        hz  = m_hazard();
        acc = in_valid && m_ready();
        iss = m_valid && out_ready && m_flags[0] && !flush;
        if (hz && m_stall < 65535) m_stall++;
        if (wb_valid) m_busy[wb_rd] = 0;
        if (iss) m_busy[m_rd] = 1;
        if (acc) begin
          m_valid = 1; m_op = in_instr[15:12]; m_rd = in_instr[11:10];
          m_ra = in_instr[9:8]; m_rb = in_instr[1:0]; m_c = in_instr[7:0];
          m_flags = dec_flags(m_op);
        end else if (flush || (m_valid && out_ready)) begin
          m_valid = 0;
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", in_ready, m_ready());
      chk("out_valid", out_valid, m_valid);
      chk("out_rd", out_rd, m_rd);
      chk("out_ra", out_ra, m_ra);
      chk("out_rb", out_rb, m_rb);
      chk("out_c", out_c, m_c);
      chk("out_seltype", out_seltype, m_op[3:2]);
      chk("out_selop", out_selop, m_op[1:0]);
      chk("out_flags", {out_selb, out_jsel, out_cbzsel, out_msel, out_memwen, out_rfen}, m_flags);
      chk("stall_cnt", stall_cnt, m_stall[15:0]);
      chk("busy", dut.busy, m_busy_vec());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_instr = '0; out_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step(2);
    rst_n = 1;
  endtask

  initial begin
    do_reset();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_stall", stall_cnt, 0);

    // basic decode
    in_valid = 1; in_instr = 16'h0A05; out_ready = 1;
    #1 chk("first_ready", in_ready, 1);
    step(1);
    chk("d0_valid", out_valid, 1);
    chk("d0_rd", out_rd, 2);
    chk("d0_ra", out_ra, 2);
    chk("d0_c", out_c, 8'h05);
    chk("d0_selb_rfen", {out_selb, out_rfen}, 2'b11);
    chk("d0_sel", {out_seltype, out_selop}, 4'h0);

    // RAW hazard on r1 until writeback
    do_reset();
    out_ready = 1; in_valid = 1; in_instr = 16'h1600;
    step(1);
    in_valid = 0;
    step(1);
    chk("h_busy1", dut.busy, 4'b0010);
    in_valid = 1; in_instr = 16'h1910;
    #1 chk("h_stall_ready", in_ready, 0);
    step(3);
    chk("h_stall3", stall_cnt, 3);
    wb_valid = 1; wb_rd = 1;
    #1 chk("h_no_bypass", in_ready, 0);
    step(1);
    wb_valid = 0;
    #1 chk("h_ready_after_wb", in_ready, 1);
    chk("h_stall4", stall_cnt, 4);
    step(1);
    chk("h_accept_valid", out_valid, 1);
    chk("h_accept_rd", out_rd, 2);
    chk("h_accept_ra", out_ra, 1);

    // downstream back-pressure
    do_reset();
    in_valid = 1; in_instr = 16'h0A05;
    step(1);
    in_instr = 16'h2000;
    #1 chk("bp_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_rd_c", {out_rd, out_c}, {2'd2, 8'h05});
    end
    out_ready = 1;
    #1 chk("bp_release_ready", in_ready, 1);
    step(1);
    chk("bp_next_c", out_c, 8'h00);
    chk("bp_next_selop", out_selop, 2);
    in_valid = 0;

    // store and jump flags
    do_reset();
    out_ready = 1; in_valid = 1; in_instr = 16'h9401;
    step(1);
    chk("st_memwen_rfen", {out_memwen, out_rfen}, 2'b10);
    in_instr = 16'hF000;
    step(1);
    chk("jmp_jsel_rfen", {out_jsel, out_rfen}, 2'b10);
    in_valid = 0;
    step(1);
    chk("st_jmp_busy", dut.busy, 4'b0000);

    // same-cycle issue/retire, then flush
    do_reset();
    out_ready = 1; in_valid = 1; in_instr = 16'h2C00;
    step(1);
    in_valid = 0; wb_valid = 1; wb_rd = 3;
    step(1);
    wb_valid = 0;
    chk("set_wins", dut.busy, 4'b1000);
    out_ready = 0; in_valid = 1; in_instr = 16'h2400;
    step(1);
    chk("fl_pre_valid", out_valid, 1);
    in_valid = 0; flush = 1; out_ready = 1;
    step(1);
    flush = 0;
    chk("fl_valid", out_valid, 0);
    chk("fl_busy", dut.busy, 4'b1000);

    // saturate the stall counter, then reset mid-stall
    in_valid = 1; in_instr = 16'h2300;
    step(65540);
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    step(2);
    chk("sat_hold", stall_cnt, 16'hFFFF);
    rst_n = 0;
    #1;
    chk("rst_stall", stall_cnt, 0);
    chk("rst_busy", dut.busy, 4'b0000);
    chk("rst_valid", out_valid, 0);
    in_valid = 0;
    step(1);
    rst_n = 1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_instr  = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      wb_valid  = ($urandom_range(0, 9) < 3);
      wb_rd     = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 19) == 0);
      step(1);
    end
    idle_inputs();
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/id_pipe_dec.md
ID_PIPE_DEC -- requirements
Module: id_pipe_dec

Interface
REQ-001 Parameter IW, 16, instruction width in bits.
REQ-002 Parameter RW, 2, register-ID width; register count NREG = 2**RW.
REQ-003 Parameter CW, 8, immediate width; legal only when 4+2*RW+CW <= IW.
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid / in_ready  in / out  1 / 1  instruction handshake, upstream side.
REQ-007 in_instr  in  IW  instruction: opcode=[IW-1:IW-4], rd=next RW bits down, ra=next RW bits down, rb=[RW-1:0], c=[CW-1:0].
REQ-008 out_valid / out_ready  out / in  1 / 1  decoded-bundle handshake, downstream side.
REQ-009 out_rd, out_ra, out_rb  out  RW each  registered register IDs.
REQ-010 out_c  out  CW  registered immediate.
REQ-011 out_seltype, out_selop  out  2 each  opcode[3:2], opcode[1:0].
REQ-012 out_selb, out_jsel, out_cbzsel, out_msel, out_memwen, out_rfen  out  1 each  registered control flags.
REQ-013 wb_valid, wb_rd  in  1, RW  writeback retire: clears busy bit wb_rd.
REQ-014 flush  in  1  synchronous discard of output stage.
REQ-015 stall_cnt  out  16  saturating count of hazard-stall cycles.
REQ-016 dvdd, dgnd  inout  1 each  module supply/ground, no logic function.

Function
REQ-017 Control decode: selb=1 for opcodes 0,8,9,A,D,E,F; memwen=(op==9); rfen=op not in {9,E,F}; jsel=(op==F); msel=(op==8); cbzsel=(op==E).
REQ-018 Source reads: ra read for all opcodes except A and F; rb read when selb=0; rd read as store data when op==9.
REQ-019 Scoreboard: busy[NREG-1:0] register; busy[r]=1 means a write to r issued downstream and not yet retired.
REQ-020 Hazard when in_valid and any read register, or rd when rfen=1, is busy, or equals out_rd while out_valid=1 and out_rfen=1.
REQ-021 Hazard uses registered busy only; no same-cycle wb bypass; stalled instruction proceeds one cycle after retire.
REQ-022 in_ready = (!out_valid | out_ready) & !hazard & !flush.
REQ-023 Accept (in_valid & in_ready): decoded fields load into output registers, out_valid=1 next cycle; latency 1 cycle.
REQ-024 Output handshake with no accept that cycle: out_valid=0 next cycle; output fields hold.
REQ-025 out_valid=1 & out_ready=0: all outputs hold stable.
REQ-026 Issue (out_valid & out_ready & out_rfen): busy[out_rd] set next cycle.
REQ-027 wb_valid clears busy[wb_rd] next cycle; same-cycle issue and retire to one register: set wins, busy stays 1.
REQ-028 flush: out_valid=0 next cycle, no accept, no busy set for discarded bundle; busy bits unaffected otherwise.
REQ-029 stall_cnt +1 each cycle with in_valid & hazard; saturates at 16'hFFFF, no wrap.
REQ-030 wb_valid for a non-busy register: no effect.

Reset
REQ-031 rst_n low asynchronously forces out_valid=0, all out_* fields 0, busy=0, stall_cnt=0.
REQ-032 Reset mid-operation discards held bundle and all pending busy bits; in_ready reflects post-reset state on first cycle after release.

Verification
REQ-033 Reset then instr 16'h0A05 valid, out_ready=1 -> next cycle out_valid=1, rd=2, ra=2, c=8'h05, selb=1, rfen=1, seltype=0, selop=0.
REQ-034 Issue 16'h1600 (rd=1), no wb; then 16'h1910 (ra=1) -> in_ready=0, stall_cnt increments per cycle; wb_valid rd=1 -> accept one cycle after busy clears.
REQ-035 out_ready=0 with out_valid=1, new in_valid -> in_ready=0, outputs stable 5 cycles; out_ready=1 -> hand-off, next bundle loaded same edge.
REQ-036 16'h9401 (ST) and 16'hF000 (JMP) -> memwen=1/rfen=0 and jsel=1/rfen=0; no busy bits set on issue.
REQ-037 Issue to r3 and wb_valid wb_rd=3 same cycle -> busy[3]=1; flush with out_valid=1 -> out_valid=0, busy unchanged.
REQ-038 Force 65540 hazard cycles -> stall_cnt=16'hFFFF held; assert rst_n low mid-stall -> stall_cnt=0, busy=0 immediately.
